// File: rtl/uart_tx_fifo_drain_pkg.sv
// uart_tx_fifo_drain_pkg: shared state encoding, parity modes and baud-counter sizing
package uart_tx_fifo_drain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int CLKS_PER_BIT_DEF = 434;
    localparam int BAUD_W           = $clog2(CLKS_PER_BIT_DEF);

    // Baud counter width for an arbitrary bit period (CLKS_PER_BIT >= 2).
    function automatic int baud_w(input int clks);
        return $clog2(clks);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_baud.sv
// baud_tick_gen: bit-period counter; tick_o marks the last cycle of each bit period
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   restart_i in  hold the counter at zero (no tick while asserted)
//   tick_o    out high on the final cycle of a CLKS-cycle period
module baud_tick_gen #(
    parameter int CLKS = 434,
    parameter int W    = $clog2(CLKS)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic tick_o
);

    logic [W-1:0] cnt_q;

    assign tick_o = !restart_i && (cnt_q == W'(CLKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= (restart_i || tick_o) ? '0 : cnt_q + W'(1);
    end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops bytes from the TX FIFO and serializes them as UART frames
//   clk         in  system clock, rising edge
//   rst_n       in  asynchronous active-low reset
//   en          in  drain enable, sampled only in IDLE
//   fifo_empty  in  FIFO empty flag
//   fifo_data   in  FIFO head byte, valid when fifo_empty=0
//   fifo_rden   out one-cycle pop strobe
//   tx          out registered serial line, idle high
//   busy        out high from the pop cycle through the last stop-bit cycle
//   frame_done  out pulse on the final cycle of the last stop bit
//   frames_sent out completed frame count, wraps
import uart_tx_fifo_drain_pkg::*;

module uart_tx_fifo_drain #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_rden,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frames_sent
);

    localparam int BW = baud_w(CLKS_PER_BIT);

    state_e      state_q, state_d;
    logic [7:0]  sh_q, sh_d;
    logic [2:0]  idx_q, idx_d;
    logic        par_q, par_d;
    logic        tx_q, tx_d;
    logic [15:0] frames_sent_q;
    logic        tick;

    assign fifo_rden   = (state_q == ST_IDLE) && en && !fifo_empty && rst_n;
    assign busy        = (state_q != ST_IDLE) || fifo_rden;
    // idx_q doubles as the stop-bit index while in STOP
    assign frame_done  = (state_q == ST_STOP) && tick && (idx_q == 3'(STOP_BITS - 1));
    assign tx          = tx_q;
    assign frames_sent = frames_sent_q;

    baud_tick_gen #(
        .CLKS (CLKS_PER_BIT),
        .W    (BW)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart_i (state_q == ST_IDLE),
        .tick_o    (tick)
    );

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        par_d   = par_q;
        case (state_q)
            ST_IDLE: if (fifo_rden) begin
                state_d = ST_START;
                sh_d    = fifo_data;
                par_d   = (^fifo_data) ^ (PARITY == PARITY_ODD);
            end
            ST_START: if (tick) state_d = ST_DATA;
            ST_DATA: if (tick) begin
                idx_d = idx_q + 3'd1;
                sh_d  = sh_q >> 1;
                if (idx_q == 3'd7) state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (tick) state_d = ST_STOP;
            ST_STOP: if (tick) begin
                idx_d   = frame_done ? 3'd0 : idx_q + 3'd1;
                state_d = frame_done ? ST_IDLE : ST_STOP;
            end
            default: state_d = ST_IDLE;
        endcase
        // tx is driven from the next state so the line changes on the same edge as the state
        tx_d = (state_d == ST_START)  ? 1'b0    :
               (state_d == ST_DATA)   ? sh_d[0] :
               (state_d == ST_PARITY) ? par_d   : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sh_q          <= '0;
            idx_q         <= '0;
            par_q         <= 1'b0;
            tx_q          <= 1'b1;
            frames_sent_q <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            if (frame_done) frames_sent_q <= frames_sent_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain: two drains (8N1 and 8O2, 4 clocks/bit) against a frame-level reference model
module tb_uart_tx_fifo_drain;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en         [2];
    logic        fifo_empty [2];
    logic [7:0]  fifo_data  [2];
    logic        rden       [2];
    logic        tx         [2];
    logic        busy       [2];
    logic        done       [2];
    logic [15:0] cnt        [2];

    int checks = 0;
    int failures = 0;

    // frame configuration of each instance
    int ppar  [2] = '{0, 2};
    int pstop [2] = '{1, 2};

    // bench FIFOs and reference model state
    logic [7:0]  fq [2][$];
    bit          act [2];
    int          pos [2];
    logic [7:0]  mb [2];
    logic [15:0] mcnt [2];
    bit          prev_rden [2];
    int          pops [2];
    int          dones [2];
    int          pop_cyc [2][$];
    int          done_cyc [2][$];
    int          cyc = 0;

    uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data[0]),
        .fifo_rden(rden[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(done[0]), .frames_sent(cnt[0]));

    uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data[1]),
        .fifo_rden(rden[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(done[1]), .frames_sent(cnt[1]));

    always #5 clk = ~clk;

    function automatic int flen(input int d);
        return (9 + ((ppar[d] != 0) ? 1 : 0) + pstop[d]) * CPB;
    endfunction

    // Line level at cycle p of a frame carrying byte b (p=0 is the first start-bit cycle).
    function automatic logic frame_bit(input logic [7:0] b, input int p, input int par);
        int k = p / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (par != 0 && k == 9) return (par == 1) ? ^b : ~^b;
        return 1'b1;
    endfunction

    function automatic void refresh(input int d);
        fifo_empty[d] = (fq[d].size() == 0);
        fifo_data[d]  = (fq[d].size() == 0) ? 8'h00 : fq[d][0];
    endfunction

    // Advance the model for the rising edge just passed, then check every output mid-cycle.
    always @(negedge clk) begin
        logic etx, erd, ebusy, edone;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (act[d]) begin
                if (pos[d] == flen(d) - 1) begin
                    act[d] = 0;
                    mcnt[d] = mcnt[d] + 16'd1;
                end else pos[d]++;
            end
            if (prev_rden[d] && fq[d].size() != 0) begin
                mb[d] = fq[d].pop_front();
                act[d] = 1;
                pos[d] = 0;
            end
            if (!rst_n) begin
                act[d] = 0;
                mcnt[d] = 16'h0;
            end
            refresh(d);
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            erd   = !act[d] && en[d] && !fifo_empty[d] && rst_n;
            etx   = act[d] ? frame_bit(mb[d], pos[d], ppar[d]) : 1'b1;
            ebusy = act[d] || erd;
            edone = act[d] && (pos[d] == flen(d) - 1);
            checks += 5;
            if (tx[d] !== etx) begin failures++; $display("FAIL tx dut%0d cyc=%0d got=%b exp=%b", d, cyc, tx[d], etx); end
            if (rden[d] !== erd) begin failures++; $display("FAIL fifo_rden dut%0d cyc=%0d got=%b exp=%b", d, cyc, rden[d], erd); end
            if (busy[d] !== ebusy) begin failures++; $display("FAIL busy dut%0d cyc=%0d got=%b exp=%b", d, cyc, busy[d], ebusy); end
            if (done[d] !== edone) begin failures++; $display("FAIL frame_done dut%0d cyc=%0d got=%b exp=%b", d, cyc, done[d], edone); end
            if (cnt[d] !== mcnt[d]) begin failures++; $display("FAIL frames_sent dut%0d cyc=%0d got=%h exp=%h", d, cyc, cnt[d], mcnt[d]); end
            if (rden[d] === 1'b1) begin pops[d]++; pop_cyc[d].push_back(cyc); end
            if (done[d] === 1'b1) begin dones[d]++; done_cyc[d].push_back(cyc); end
            prev_rden[d] = erd;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int d, input logic [7:0] b);
        fq[d].push_back(b);
        refresh(d);
    endtask

    task automatic wait_idle(input int d, input int lim);
        int n = 0;
        while ((act[d] || prev_rden[d] || (en[d] && fq[d].size() != 0)) && n < lim) begin
            step();
            n++;
        end
        checks++;
        if (n >= lim) begin failures++; $display("FAIL wait_idle dut%0d: still busy after %0d cycles, exp idle", d, lim); end
        repeat (2) step();
    endtask

    task automatic test_reset();
        en[0] = 1'b1;
        push(0, 8'h3C);
        push(0, 8'h11);
        repeat (3) step();
        checks += 6;
        if (tx[0] !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx[0]); end
        if (busy[0] !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy[0]); end
        if (done[0] !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done[0]); end
        if (cnt[0] !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=0000", cnt[0]); end
        if (rden[0] !== 1'b0) begin failures++; $display("FAIL reset_rden got=%b exp=0", rden[0]); end
        if (fq[0].size() != 2) begin failures++; $display("FAIL reset_no_pop fifo_level got=%0d exp=2", fq[0].size()); end
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        while (!(act[0] && pos[0] >= 16 && pos[0] <= 18) && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n >= 100) begin failures++; $display("FAIL midreset_reach_bit3 waited=%0d exp<100", n); end
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (tx[0] !== 1'b1) begin failures++; $display("FAIL midreset_tx got=%b exp=1", tx[0]); end
        if (busy[0] !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy[0]); end
        if (cnt[0] !== 16'h0) begin failures++; $display("FAIL midreset_count got=%h exp=0000", cnt[0]); end
        if (rden[0] !== 1'b0) begin failures++; $display("FAIL midreset_rden got=%b exp=0", rden[0]); end
        repeat (3) step();
        checks++;
        if (fq[0].size() != 1) begin failures++; $display("FAIL midreset_no_pop fifo_level got=%0d exp=1", fq[0].size()); end
        rst_n = 1'b1;
        wait_idle(0, 200);
        checks++;
        if (cnt[0] !== 16'd1) begin failures++; $display("FAIL midreset_after_count got=%h exp=0001", cnt[0]); end
    endtask

    task automatic test_single();
        int p0 = pops[0];
        int d0 = dones[0];
        logic [15:0] c0 = cnt[0];
        push(0, 8'hA5);
        wait_idle(0, 100);
        checks += 4;
        if (pops[0] - p0 != 1) begin failures++; $display("FAIL single_pops got=%0d exp=1", pops[0] - p0); end
        if (dones[0] - d0 != 1) begin failures++; $display("FAIL single_done_pulses got=%0d exp=1", dones[0] - d0); end
        if (cnt[0] !== c0 + 16'd1) begin failures++; $display("FAIL single_count got=%h exp=%h", cnt[0], c0 + 16'd1); end
        if (done_cyc[0][$] - pop_cyc[0][$] != 40) begin failures++; $display("FAIL single_length got=%0d exp=40", done_cyc[0][$] - pop_cyc[0][$]); end
    endtask

    task automatic test_back_to_back();
        int p0 = pops[0];
        logic [15:0] c0 = cnt[0];
        int n;
        en[0] = 1'b0;
        push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h55);
        step();
        en[0] = 1'b1;
        wait_idle(0, 300);
        n = pop_cyc[0].size();
        checks += 4;
        if (pops[0] - p0 != 3) begin failures++; $display("FAIL b2b_pops got=%0d exp=3", pops[0] - p0); end
        if (cnt[0] !== c0 + 16'd3) begin failures++; $display("FAIL b2b_count got=%h exp=%h", cnt[0], c0 + 16'd3); end
        if (pop_cyc[0][n-2] - pop_cyc[0][n-3] != 41) begin failures++; $display("FAIL b2b_spacing1 got=%0d exp=41", pop_cyc[0][n-2] - pop_cyc[0][n-3]); end
        if (pop_cyc[0][n-1] - pop_cyc[0][n-2] != 41) begin failures++; $display("FAIL b2b_spacing2 got=%0d exp=41", pop_cyc[0][n-1] - pop_cyc[0][n-2]); end
    endtask

    task automatic test_parity_stop();
        int p0 = pops[1];
        logic [15:0] c0 = cnt[1];
        en[1] = 1'b1;
        push(1, 8'h07);
        wait_idle(1, 100);
        checks += 3;
        if (pops[1] - p0 != 1) begin failures++; $display("FAIL par_pops got=%0d exp=1", pops[1] - p0); end
        if (cnt[1] !== c0 + 16'd1) begin failures++; $display("FAIL par_count got=%h exp=%h", cnt[1], c0 + 16'd1); end
        if (done_cyc[1][$] - pop_cyc[1][$] != 48) begin failures++; $display("FAIL par_length got=%0d exp=48", done_cyc[1][$] - pop_cyc[1][$]); end
    endtask

    task automatic test_enable_gating();
        int p0 = pops[0];
        logic [15:0] c0 = cnt[0];
        int n = 0;
        en[0] = 1'b0;
        push(0, 8'h12);
        repeat (20) step();
        checks += 2;
        if (fq[0].size() != 1) begin failures++; $display("FAIL gate_level got=%0d exp=1", fq[0].size()); end
        if (pops[0] != p0) begin failures++; $display("FAIL gate_pops got=%0d exp=%0d", pops[0], p0); end
        push(0, 8'h34);
        en[0] = 1'b1;
        while (!(act[0] && pos[0] >= 12) && n < 50) begin
            step();
            n++;
        end
        en[0] = 1'b0;
        wait_idle(0, 100);
        repeat (20) step();
        checks += 3;
        if (fq[0].size() != 1) begin failures++; $display("FAIL gate_after_level got=%0d exp=1", fq[0].size()); end
        if (pops[0] - p0 != 1) begin failures++; $display("FAIL gate_after_pops got=%0d exp=1", pops[0] - p0); end
        if (cnt[0] !== c0 + 16'd1) begin failures++; $display("FAIL gate_count got=%h exp=%h", cnt[0], c0 + 16'd1); end
        en[0] = 1'b1;
        wait_idle(0, 100);
    endtask

    task automatic test_wrap();
        force dut0.frames_sent_q = 16'hFFFE;
        mcnt[0] = 16'hFFFE;
        #1;
        release dut0.frames_sent_q;
        push(0, 8'hC3);
        push(0, 8'h5A);
        wait_idle(0, 200);
        checks++;
        if (cnt[0] !== 16'h0000) begin failures++; $display("FAIL wrap_count got=%h exp=0000", cnt[0]); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            int d = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0 && fq[d].size() < 16) push(d, 8'($urandom));
            if ($urandom_range(0, 49) == 0) en[d] = ~en[d];
            step();
        end
        en[0] = 1'b1;
        en[1] = 1'b1;
        wait_idle(0, 2000);
        wait_idle(1, 2000);
        checks += 2;
        if (fq[0].size() != 0) begin failures++; $display("FAIL rand_drain0 level got=%0d exp=0", fq[0].size()); end
        if (fq[1].size() != 0) begin failures++; $display("FAIL rand_drain1 level got=%0d exp=0", fq[1].size()); end
    endtask

    initial begin
        en[0] = 1'b0;
        en[1] = 1'b0;
        refresh(0);
        refresh(1);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        test_reset();
        test_reset_mid_frame();
        test_single();
        test_back_to_back();
        test_parity_stop();
        test_enable_gating();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
